lsu_dccm_arb: RTL and testbench
===============================

LSU_DCCM_ARB -- requirements
Module: lsu_dccm_arb

Interface
REQ-001 SHALL have parameter DMA_DEPTH, default 2, meaning DMA request queue entries (power of two, 2..4).
REQ-002 SHALL have parameter STARVE_MAX, default 8, meaning cycles a queued DMA head may wait before forced priority.
REQ-003 SHALL have parameter DMA_BURST, default 2, meaning maximum consecutive DMA grants in forced-priority mode.
REQ-004 SHALL have port clk, input, 1, the single clock for all state.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports core_valid, input, 1; core_addr, input, 32; core_size, input, 2 (0 byte, 1 half, 2 word); core_store, input, 1; core_wdata, input, 32.
REQ-007 SHALL have port core_grant, output, 1, core request accepted this cycle.
REQ-008 SHALL have ports dma_req_valid, input, 1; dma_req_addr, input, 32; dma_req_size, input, 2; dma_req_write, input, 1; dma_req_wdata, input, 32; dma_req_ready, output, 1.
REQ-009 SHALL have port pipe_freeze, input, 1, dc1 pipe stalled; no grant issued.
REQ-010 SHALL have ports pipe_valid, output, 1; pipe_dma, output, 1; pipe_addr, output, 32; pipe_size, output, 2; pipe_store, output, 1; pipe_wdata, output, 32: registered dc1 packet.
REQ-011 SHALL have port dma_starved, output, 1, high while in DMA_PRI state.

Function
REQ-012 DMA side SHALL buffer requests in a DMA_DEPTH-entry FIFO; dma_req_ready = FIFO not full; push on valid&ready.
REQ-013 Push and pop in the same cycle on a full FIFO SHALL NOT be allowed (ready low when full); on a non-full, non-empty FIFO simultaneous push/pop SHALL leave count unchanged.
REQ-014 Pointers SHALL wrap modulo DMA_DEPTH; count SHALL be log2(DMA_DEPTH)+1 bits.
REQ-015 FSM states SHALL be CORE_PRI (reset state) and DMA_PRI.
REQ-016 CORE_PRI: if ~pipe_freeze, grant core when core_valid; else grant FIFO head if non-empty.
REQ-017 DMA_PRI: if ~pipe_freeze, grant FIFO head if non-empty; else grant core when core_valid.
REQ-018 At most one grant per cycle; no grant when pipe_freeze=1; core_grant SHALL be combinational from current inputs and state.
REQ-019 wait_cnt SHALL increment (saturating at STARVE_MAX) each cycle FIFO is non-empty and no DMA grant occurs, and clear on any DMA grant or when FIFO is empty.
REQ-020 CORE_PRI->DMA_PRI SHALL occur when wait_cnt == STARVE_MAX-1 and a further cycle without DMA grant occurs; burst_cnt clears on entry.
REQ-021 DMA_PRI->CORE_PRI SHALL occur after DMA_BURST DMA grants or when the FIFO becomes empty, whichever first.
REQ-022 Granted request SHALL appear on pipe_* one cycle later with pipe_valid=1; pipe_dma=1 for DMA grants; pipe_store from core_store or dma_req_write.
REQ-023 Without a grant pipe_valid SHALL be 0 next cycle; when pipe_freeze=1 pipe_* SHALL hold their value.
REQ-024 Latency: empty FIFO, DMA request accepted cycle N is granted no earlier than N+1, appears on pipe at N+2.

Reset
REQ-025 On rst, FIFO SHALL empty, wait_cnt=0, burst_cnt=0, state=CORE_PRI, pipe_valid=0, pipe_dma=0, pipe_addr/size/store/wdata=0, dma_starved=0; dma_req_ready=1 after release.
REQ-026 Reset asserted mid-operation SHALL discard queued DMA entries and the in-flight pipe packet with no grant in that cycle.

Structure
REQ-027 State enum and size encoding constants SHALL live in the shared LSU package alongside lsu_pkt_t.
REQ-028 The DMA FIFO SHALL be a sub-module lsu_dma_fifo parameterised by DMA_DEPTH and payload width.

Verification
REQ-029 Core only: core_valid=1 addr 0xF004_0000 word, no DMA -> core_grant same cycle, pipe_valid=1 pipe_dma=0 pipe_addr=0xF004_0000 next cycle.
REQ-030 Starvation: core_valid held 1, one DMA push at cycle 0 -> DMA granted exactly after STARVE_MAX=8 waiting cycles, dma_starved=1 that cycle, returns CORE_PRI after FIFO empties.
REQ-031 Burst cap: FIFO full (2), four more pushes pending, core continuous -> in DMA_PRI exactly 2 DMA grants then core grant.
REQ-032 Freeze: pipe_freeze=1 for 3 cycles with both requesters valid -> no grants, pipe_* unchanged, wait_cnt still counts.
REQ-033 Full FIFO: 2 pushes with no grants (freeze) -> dma_req_ready=0; third request not accepted until a pop.
REQ-034 Reset mid-burst: rst asserted in DMA_PRI with 2 queued -> all outputs at REQ-025 values immediately, no grant after release until new request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU package.
// Holds the arbiter state encoding, the access-size encoding and the packet
// layout that travels from the request side into the dc1 pipe stage.
//   arb_state_t : CORE_PRI (reset state) / DMA_PRI (starvation relief)
//   SIZE_*      : 0 byte, 1 half, 2 word
//   lsu_pkt_t   : addr / size / store / wdata as one packed payload
package lsu_pkg;

  typedef enum logic {
    CORE_PRI = 1'b0,
    DMA_PRI  = 1'b1
  } arb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        store;
    logic [31:0] wdata;
  } lsu_pkt_t;

  localparam int LSU_PKT_W = $bits(lsu_pkt_t);

  function automatic lsu_pkt_t make_pkt(input logic [31:0] addr,
                                        input logic [1:0]  size,
                                        input logic        store,
                                        input logic [31:0] wdata);
    lsu_pkt_t p;
    p.addr  = addr;
    p.size  = size;
    p.store = store;
    p.wdata = wdata;
    return p;
  endfunction

endpackage

// File: rtl/lsu_dma_fifo.sv
// Small DMA request queue in front of the DCCM arbiter.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (queue empties)
//   push, push_data : write one entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry, valid when !empty
//   full, empty     : occupancy flags
//   count           : number of stored entries (log2(DEPTH)+1 bits)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module lsu_dma_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 67
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  // Storage carries no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_dccm_arb.sv
// DCCM port arbiter between the core LSU and a DMA requester.
// The core normally wins; DMA requests wait in a small queue. When the queue
// head has waited STARVE_MAX cycles the arbiter flips to DMA_PRI and serves
// up to DMA_BURST DMA requests (or until the queue drains) before handing
// priority back to the core. The winner is registered into the dc1 packet.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   core_valid/addr/size/store/wdata, core_grant : core request, same-cycle grant
//   dma_req_valid/addr/size/write/wdata, dma_req_ready : DMA request handshake
//   pipe_freeze              : dc1 stalled; no grant, pipe packet holds
//   pipe_valid/dma/addr/size/store/wdata : registered dc1 packet
//   dma_starved              : high while in DMA_PRI (exposes the FSM state)
// Handshake: a DMA request transfers on a rising edge where dma_req_valid and
// dma_req_ready are both high; ready depends only on queue occupancy (and is
// low during reset), never on dma_req_valid. The core has no ready: it keeps
// core_valid asserted until it sees core_grant in the same cycle.
module lsu_dccm_arb
  import lsu_pkg::*;
#(
  parameter int DMA_DEPTH  = 2,
  parameter int STARVE_MAX = 8,
  parameter int DMA_BURST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  input  logic [31:0] core_addr,
  input  logic [1:0]  core_size,
  input  logic        core_store,
  input  logic [31:0] core_wdata,
  output logic        core_grant,
  input  logic        dma_req_valid,
  input  logic [31:0] dma_req_addr,
  input  logic [1:0]  dma_req_size,
  input  logic        dma_req_write,
  input  logic [31:0] dma_req_wdata,
  output logic        dma_req_ready,
  input  logic        pipe_freeze,
  output logic        pipe_valid,
  output logic        pipe_dma,
  output logic [31:0] pipe_addr,
  output logic [1:0]  pipe_size,
  output logic        pipe_store,
  output logic [31:0] pipe_wdata,
  output logic        dma_starved
);

  localparam int CNT_W   = $clog2(DMA_DEPTH) + 1;
  localparam int WAIT_W  = $clog2(STARVE_MAX + 1);
  localparam int BURST_W = $clog2(DMA_BURST + 1);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;

  lsu_pkt_t           core_pkt;
  lsu_pkt_t           dma_pkt;
  lsu_pkt_t           fifo_head;
  lsu_pkt_t           pipe_pkt;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               dma_push;
  logic               dma_grant;
  logic               fifo_drains;

  assign core_pkt = make_pkt(core_addr, core_size, core_store, core_wdata);
  assign dma_pkt  = make_pkt(dma_req_addr, dma_req_size, dma_req_write, dma_req_wdata);

  assign dma_req_ready = !rst && !fifo_full;
  assign dma_push      = dma_req_valid && dma_req_ready;

  lsu_dma_fifo #(
    .DEPTH (DMA_DEPTH),
    .WIDTH (LSU_PKT_W)
  ) u_dma_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dma_push),
    .push_data (dma_pkt),
    .pop       (dma_grant),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Single-winner grant; reset and freeze suppress both grants.
  always_comb begin
    core_grant = 1'b0;
    dma_grant  = 1'b0;
    if (!rst && !pipe_freeze) begin
      if (state == CORE_PRI) begin
        if (core_valid)       core_grant = 1'b1;
        else if (!fifo_empty) dma_grant  = 1'b1;
      end else begin
        if (!fifo_empty)      dma_grant  = 1'b1;
        else if (core_valid)  core_grant = 1'b1;
      end
    end
  end

  // Queue is empty after this edge: last entry popped with nothing arriving,
  // or already empty with nothing arriving.
  assign fifo_drains = !dma_push &&
                       (fifo_empty || (dma_grant && fifo_count == CNT_W'(1)));

  always_comb begin
    state_next = state;
    case (state)
      CORE_PRI: begin
        // wait_cnt already shows STARVE_MAX-1 waited cycles; this cycle is
        // the STARVE_MAX-th without service.
        if (!fifo_empty && !dma_grant && wait_cnt == WAIT_W'(STARVE_MAX - 1)) begin
          state_next = DMA_PRI;
        end
      end
      DMA_PRI: begin
        if ((dma_grant && burst_cnt == BURST_W'(DMA_BURST - 1)) || fifo_drains) begin
          state_next = CORE_PRI;
        end
      end
      default: state_next = CORE_PRI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CORE_PRI;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_next;

      if (fifo_empty || dma_grant) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_W'(STARVE_MAX)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (state == CORE_PRI && state_next == DMA_PRI) begin
        burst_cnt <= '0;
      end else if (state == DMA_PRI && dma_grant) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end

  // dc1 packet: payload only reloads on a grant; a frozen stage holds all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_dma   <= 1'b0;
      pipe_pkt   <= '0;
    end else if (!pipe_freeze) begin
      pipe_valid <= core_grant || dma_grant;
      pipe_dma   <= dma_grant;
      if (dma_grant) begin
        pipe_pkt <= fifo_head;
      end else if (core_grant) begin
        pipe_pkt <= core_pkt;
      end
    end
  end

  assign pipe_addr   = pipe_pkt.addr;
  assign pipe_size   = pipe_pkt.size;
  assign pipe_store  = pipe_pkt.store;
  assign pipe_wdata  = pipe_pkt.wdata;
  assign dma_starved = (state == DMA_PRI);

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Bench for lsu_dccm_arb: directed scenarios followed by a randomized run,
// every cycle compared against a queue-based model of the arbitration rules.
module tb_lsu_dccm_arb;

  localparam int DMA_DEPTH  = 2;
  localparam int STARVE_MAX = 8;
  localparam int DMA_BURST  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        core_valid;
  logic [31:0] core_addr;
  logic [1:0]  core_size;
  logic        core_store;
  logic [31:0] core_wdata;
  logic        core_grant;
  logic        dma_req_valid;
  logic [31:0] dma_req_addr;
  logic [1:0]  dma_req_size;
  logic        dma_req_write;
  logic [31:0] dma_req_wdata;
  logic        dma_req_ready;
  logic        pipe_freeze;
  logic        pipe_valid;
  logic        pipe_dma;
  logic [31:0] pipe_addr;
  logic [1:0]  pipe_size;
  logic        pipe_store;
  logic [31:0] pipe_wdata;
  logic        dma_starved;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_dccm_arb #(
    .DMA_DEPTH  (DMA_DEPTH),
    .STARVE_MAX (STARVE_MAX),
    .DMA_BURST  (DMA_BURST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_valid    (core_valid),
    .core_addr     (core_addr),
    .core_size     (core_size),
    .core_store    (core_store),
    .core_wdata    (core_wdata),
    .core_grant    (core_grant),
    .dma_req_valid (dma_req_valid),
    .dma_req_addr  (dma_req_addr),
    .dma_req_size  (dma_req_size),
    .dma_req_write (dma_req_write),
    .dma_req_wdata (dma_req_wdata),
    .dma_req_ready (dma_req_ready),
    .pipe_freeze   (pipe_freeze),
    .pipe_valid    (pipe_valid),
    .pipe_dma      (pipe_dma),
    .pipe_addr     (pipe_addr),
    .pipe_size     (pipe_size),
    .pipe_store    (pipe_store),
    .pipe_wdata    (pipe_wdata),
    .dma_starved   (dma_starved)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [66:0] exp_q[$];     // queued DMA requests, {addr,size,write,wdata}
  int          m_wait;       // cycles the queue head has gone unserved
  int          m_burst;      // DMA grants since forced priority began
  bit          m_starve;     // forced DMA priority active
  logic        m_pv, m_pd, m_pst;
  logic [31:0] m_pa, m_pw;
  logic [1:0]  m_ps;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wait   = 0;
    m_burst  = 0;
    m_starve = 0;
    m_pv = 1'b0; m_pd = 1'b0; m_pst = 1'b0;
    m_pa = '0;   m_pw = '0;   m_ps  = '0;
  endtask

  // Called with inputs already driven just after a falling edge. Compares all
  // outputs against the model, crosses the rising edge, advances the model,
  // and returns at the next falling edge.
  task automatic tick();
    logic        ready_e, g_core, g_dma;
    int          old_size, old_wait;
    logic [66:0] cpkt, dpkt;
    #1;
    if (rst) model_reset();
    ready_e = !rst && (exp_q.size() < DMA_DEPTH);
    g_core  = 1'b0;
    g_dma   = 1'b0;
    if (!rst && !pipe_freeze) begin
      if (m_starve) begin
        if (exp_q.size() > 0) g_dma  = 1'b1;
        else if (core_valid)  g_core = 1'b1;
      end else begin
        if (core_valid)             g_core = 1'b1;
        else if (exp_q.size() > 0)  g_dma  = 1'b1;
      end
    end
    chk1 ("core_grant",    core_grant,    g_core);
    chk1 ("dma_req_ready", dma_req_ready, ready_e);
    chk1 ("dma_starved",   dma_starved,   m_starve);
    chk1 ("pipe_valid",    pipe_valid,    m_pv);
    chk1 ("pipe_dma",      pipe_dma,      m_pd);
    chk32("pipe_addr",     pipe_addr,     m_pa);
    chk32("pipe_size",     {30'd0, pipe_size}, {30'd0, m_ps});
    chk1 ("pipe_store",    pipe_store,    m_pst);
    chk32("pipe_wdata",    pipe_wdata,    m_pw);
    cpkt = {core_addr, core_size, core_store, core_wdata};
    dpkt = {dma_req_addr, dma_req_size, dma_req_write, dma_req_wdata};
    @(posedge clk);
    if (!rst) begin
      old_size = exp_q.size();
      old_wait = m_wait;
      if (!pipe_freeze) begin
        m_pv = g_core | g_dma;
        m_pd = g_dma;
        if (g_dma)       {m_pa, m_ps, m_pst, m_pw} = exp_q[0];
        else if (g_core) {m_pa, m_ps, m_pst, m_pw} = cpkt;
      end
      if (old_size > 0 && !g_dma) m_wait = (old_wait < STARVE_MAX) ? old_wait + 1 : STARVE_MAX;
      else                        m_wait = 0;
      if (g_dma) void'(exp_q.pop_front());
      if (dma_req_valid && ready_e) exp_q.push_back(dpkt);
      if (!m_starve) begin
        if (old_size > 0 && !g_dma && old_wait == STARVE_MAX - 1) begin
          m_starve = 1;
          m_burst  = 0;
        end
      end else begin
        if (g_dma) m_burst++;
        if (m_burst == DMA_BURST || exp_q.size() == 0) m_starve = 0;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1;
    core_valid = 1'b1; core_addr = 32'h0000_0100; core_size = 2'd2;
    core_store = 1'b0; core_wdata = '0;
    dma_req_valid = 1'b0; dma_req_addr = '0; dma_req_size = '0;
    dma_req_write = 1'b0; dma_req_wdata = '0;
    pipe_freeze = 1'b0;
    model_reset();

    // reset state
    @(negedge clk);
    #1;
    chk1 ("rst_core_grant", core_grant, 1'b0);
    chk1 ("rst_pipe_valid", pipe_valid, 1'b0);
    chk32("rst_pipe_addr",  pipe_addr,  32'h0);
    chk1 ("rst_starved",    dma_starved, 1'b0);
    tick();
    rst = 1'b0; core_valid = 1'b0;
    #1 chk1("ready_after_rst", dma_req_ready, 1'b1);
    tick();

    // core only: same-cycle grant, packet one cycle later
    core_valid = 1'b1; core_addr = 32'hF004_0000; core_size = 2'd2;
    #1 chk1("core_only_grant", core_grant, 1'b1);
    tick();
    chk1 ("core_only_pv",   pipe_valid, 1'b1);
    chk1 ("core_only_pd",   pipe_dma,   1'b0);
    chk32("core_only_addr", pipe_addr,  32'hF004_0000);
    core_valid = 1'b0;
    tick();
    chk1("idle_pv_low", pipe_valid, 1'b0);

    // starvation: core saturating, one DMA request
    core_valid = 1'b1; core_addr = 32'h0000_3000;
    dma_req_valid = 1'b1; dma_req_addr = 32'h0000_1000; dma_req_size = 2'd2;
    dma_req_write = 1'b1; dma_req_wdata = 32'hCAFE_0001;
    #1 chk1("st_push_ready", dma_req_ready, 1'b1);
    tick();
    dma_req_valid = 1'b0;
    for (int i = 1; i <= STARVE_MAX; i++) begin
      #1;
      chk1("st_wait_core_grant", core_grant, 1'b1);
      chk1("st_wait_no_starve",  dma_starved, 1'b0);
      tick();
    end
    #1;
    chk1("st_starved",      dma_starved, 1'b1);
    chk1("st_core_blocked", core_grant,  1'b0);
    tick();
    chk1 ("st_pipe_dma",   pipe_dma,   1'b1);
    chk32("st_pipe_addr",  pipe_addr,  32'h0000_1000);
    chk1 ("st_pipe_store", pipe_store, 1'b1);
    #1;
    chk1("st_back_core_pri", dma_starved, 1'b0);
    chk1("st_core_again",    core_grant,  1'b1);
    tick();

    // fill the queue behind a frozen pipe
    core_valid = 1'b0; pipe_freeze = 1'b1;
    dma_req_valid = 1'b1; dma_req_addr = 32'h0000_2000; dma_req_write = 1'b0;
    #1 chk1("fill_ready0", dma_req_ready, 1'b1);
    tick();
    dma_req_addr = 32'h0000_2004;
    #1 chk1("fill_ready1", dma_req_ready, 1'b1);
    tick();
    dma_req_addr = 32'h0000_2008;
    #1 chk1("full_ready_low", dma_req_ready, 1'b0);
    tick();
    #1;
    chk1 ("full_ready_still_low", dma_req_ready, 1'b0);
    chk32("freeze_hold_addr",     pipe_addr,     32'h0000_3000);
    tick();

    // freeze with both sides requesting: no grants, packet held
    core_valid = 1'b1; core_addr = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1 ("frz_no_core_grant", core_grant, 1'b0);
      chk1 ("frz_pv_held",       pipe_valid, 1'b1);
      chk32("frz_addr_held",     pipe_addr,  32'h0000_3000);
      tick();
    end

    // unfreeze: wait count kept rising during freeze, so two core grants
    // finish the starvation window, then a capped DMA burst
    pipe_freeze = 1'b0;
    #1 chk1("uf_core_grant0", core_grant, 1'b1);
    tick();
    chk32("uf_pipe_core", pipe_addr, 32'h0000_4000);
    #1;
    chk1("uf_core_grant1", core_grant,  1'b1);
    chk1("uf_not_starved", dma_starved, 1'b0);
    tick();
    #1;
    chk1("burst_starved0", dma_starved,   1'b1);
    chk1("burst_no_core0", core_grant,    1'b0);
    chk1("burst_ready0",   dma_req_ready, 1'b0);
    tick();
    chk32("burst_addr0", pipe_addr, 32'h0000_2000);
    #1;
    chk1("burst_starved1", dma_starved,   1'b1);
    chk1("burst_ready1",   dma_req_ready, 1'b1);
    tick();
    chk32("burst_addr1", pipe_addr, 32'h0000_2004);
    dma_req_addr = 32'h0000_5000;
    #1;
    chk1("burst_cap_exit", dma_starved, 1'b0);
    chk1("burst_core_won", core_grant,  1'b1);
    tick();
    dma_req_valid = 1'b0;

    // reset while in DMA_PRI with two queued
    for (int i = 0; i < 20 && !dma_starved; i++) tick();
    chk1("rr_in_dma_pri", dma_starved, 1'b1);
    rst = 1'b1;
    #1;
    chk1 ("rr_pv",      pipe_valid,  1'b0);
    chk1 ("rr_pd",      pipe_dma,    1'b0);
    chk32("rr_addr",    pipe_addr,   32'h0);
    chk32("rr_wdata",   pipe_wdata,  32'h0);
    chk1 ("rr_starved", dma_starved, 1'b0);
    chk1 ("rr_grant",   core_grant,  1'b0);
    tick();
    rst = 1'b0; core_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("rr_post_no_grant", core_grant,    1'b0);
      chk1("rr_post_ready",    dma_req_ready, 1'b1);
      tick();
      chk1("rr_post_pv_low", pipe_valid, 1'b0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      pipe_freeze   = ($urandom_range(0, 99) < 15);
      core_valid    = ($urandom_range(0, 99) < 80);
      core_addr     = $urandom;
      core_size     = 2'($urandom_range(0, 2));
      core_store    = 1'($urandom_range(0, 1));
      core_wdata    = $urandom;
      dma_req_valid = ($urandom_range(0, 99) < 40);
      dma_req_addr  = $urandom;
      dma_req_size  = 2'($urandom_range(0, 2));
      dma_req_write = 1'($urandom_range(0, 1));
      dma_req_wdata = $urandom;
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
